// File: rtl/module_display_pkg.sv
// Shared types and constants for the BCD display driver.
// FSM states, digit count and active-low seven-segment patterns.
package module_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  localparam int DIGITS = 3;

  // seg[6:0] = g,f,e,d,c,b,a, active-low
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_encode(
    input logic [3:0] nib
  );
    logic [6:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] add3(
    input logic [3:0] n
  );
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/module_bin_to_bcd_8bit.sv
// Sequential double-dabble converter: 8-bit binary to 3-digit BCD.
// One correct-then-shift step per cycle; result published in DONE.
module module_bin_to_bcd_8bit
  import module_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  value,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);

  conv_state_t state, state_nxt;
  logic [19:0] sr;
  logic [19:0] sr_adj;
  logic [2:0]  cnt;

  assign busy = (state != IDLE);

  always_comb begin
    sr_adj = {add3(sr[19:16]),
              add3(sr[15:12]),
              add3(sr[11:8]),
              sr[7:0]};
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: if (cnt == 3'd7) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // done is a registered strobe, high in the cycle after DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      cnt  <= '0;
      bcd  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sr  <= {12'h000, value};
            cnt <= '0;
          end
        end
        SHIFT: begin
          sr  <= {sr_adj[18:0], 1'b0};
          cnt <= cnt + 3'd1;
        end
        DONE: begin
          bcd  <= sr[19:8];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/module_bcd_display_driver.sv
// 3-digit multiplexed seven-segment driver for an 8-bit count.
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module module_bcd_display_driver
  import module_display_pkg::*;
#(
  parameter int SCAN_PERIOD = 50000
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [7:0]  value,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic [11:0] bcd,
  output logic        busy
);

  localparam int PW = $clog2(SCAN_PERIOD);

  logic [PW-1:0] presc;
  logic [1:0]    digit, digit_nxt;
  logic [7:0]    captured;
  logic          start;
  logic          tc;
  logic          conv_done;
  logic [11:0]   conv_bcd;
  logic [11:0]   bcd_nxt;
  logic [3:0]    nib;
  logic          blank;
  logic          blank_h, blank_t;
  logic [2:0]    an_nxt;
  logic [6:0]    seg_nxt;

  assign start = !busy && (value != captured);
  assign tc    = (presc == PW'(SCAN_PERIOD - 1));

  module_bin_to_bcd_8bit u_conv (
    .clk   (clk_in),
    .rst_n (rst_n),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    digit_nxt = digit;
    if (tc) begin
      if (digit == 2'(DIGITS - 1)) digit_nxt = 2'd0;
      else                         digit_nxt = digit + 2'd1;
    end
  end

  // seg is built from next-state bcd/digit so it moves with an
  always_comb begin
    bcd_nxt = conv_done ? conv_bcd : bcd;
`ifdef LEADING_ZERO_BLANK_EN
    blank_h = (bcd_nxt[11:8] == 4'd0);
    blank_t = blank_h && (bcd_nxt[7:4] == 4'd0);
`else
    blank_h = 1'b0;
    blank_t = 1'b0;
`endif
    nib    = bcd_nxt[3:0];
    blank  = 1'b0;
    an_nxt = 3'b110;
    unique case (1'b1)
      (digit_nxt == 2'd1): begin
        nib    = bcd_nxt[7:4];
        blank  = blank_t;
        an_nxt = 3'b101;
      end
      (digit_nxt == 2'd2): begin
        nib    = bcd_nxt[11:8];
        blank  = blank_h;
        an_nxt = 3'b011;
      end
      default: ;
    endcase
    seg_nxt = blank ? SEG_BLANK : seg_encode(nib);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      captured <= '0;
      bcd      <= '0;
      presc    <= '0;
      digit    <= '0;
      an       <= 3'b110;
      seg      <= SEG_0;
    end else begin
      if (start) captured <= value;
      bcd   <= bcd_nxt;
      presc <= tc ? '0 : presc + 1'b1;
      digit <= digit_nxt;
      an    <= an_nxt;
      seg   <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_module_bcd_display_driver.sv
// Self-checking bench for module_bcd_display_driver (SCAN_PERIOD = 4).
// Scoreboard of bcd updates plus a free-running scan/segment model.
module tb_module_bcd_display_driver;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b1;
  logic [7:0]  value  = 8'd0;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic [11:0] bcd;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [11:0] b;
    int          due;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [7:0]  v;
    logic [11:0] b;
  } vec_t;
  vec_t tab[9];

  logic [6:0] seg_tab [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  logic [11:0] model_bcd = 12'h000;
  logic [11:0] prev_bcd  = 12'h000;

  module_bcd_display_driver #(
    .SCAN_PERIOD (4)
  ) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .value  (value),
    .seg    (seg),
    .an     (an),
    .bcd    (bcd),
    .busy   (busy)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic void chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endfunction

  function automatic logic [6:0] exp_seg(
    input logic [11:0] b,
    input int          d
  );
    logic [3:0] nb;
    logic       bl;
    bl = 1'b0;
    case (d)
      0:       nb = b[3:0];
      1:       nb = b[7:4];
      default: nb = b[11:8];
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    if (d == 2 && b[11:8] == 4'd0) bl = 1'b1;
    if (d == 1 && b[11:4] == 8'd0) bl = 1'b1;
`endif
    if (bl || nb > 4'd9) return 7'h7F;
    return seg_tab[nb];
  endfunction

  // monitor: pops the scoreboard and checks the scan every cycle
  always @(posedge clk_in) begin
    sb_t e;
    int  d;
    #3;
    if (!rst_n) begin
      prev_bcd  = 12'h000;
      model_bcd = 12'h000;
    end else begin
      if (bcd !== prev_bcd) begin
        if (sb.size() == 0) begin
          chk("bcd_unexpected", {20'h0, bcd},
              {20'h0, prev_bcd});
        end else begin
          e = sb.pop_front();
          chk("bcd_value", {20'h0, bcd}, {20'h0, e.b});
          chk("bcd_latency", cyc, e.due);
          model_bcd = e.b;
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        e = sb.pop_front();
        chk("bcd_timeout", {20'h0, bcd}, {20'h0, e.b});
        model_bcd = e.b;
      end
      prev_bcd = bcd;
      d = (cyc / 4) % 3;
      chk("an_scan", {29'h0, an},
          {29'h0, ~(3'b001 << d)});
      chk("seg_scan", {25'h0, seg},
          {25'h0, exp_seg(model_bcd, d)});
    end
  end

  task automatic drive(
    input logic [7:0]  v,
    input logic [11:0] b
  );
    @(negedge clk_in);
    value = v;
    sb.push_back('{b, cyc + 11});
  endtask

  initial begin
    int         k;
    logic       busy_seen;
    logic [2:0] an_exp [3];
    logic [6:0] sg_exp [3];

    tab[0] = '{8'd7,   12'h007};
    tab[1] = '{8'd10,  12'h010};
    tab[2] = '{8'd99,  12'h099};
    tab[3] = '{8'd100, 12'h100};
    tab[4] = '{8'd128, 12'h128};
    tab[5] = '{8'd5,   12'h005};
    tab[6] = '{8'd0,   12'h000};
    tab[7] = '{8'd59,  12'h059};
    tab[8] = '{8'd200, 12'h200};
    an_exp = '{3'b110, 3'b101, 3'b011};
    sg_exp = '{7'h00, 7'h24, 7'h79};

    // reset with value 0
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_bcd",  {20'h0, bcd},  32'h000);
    chk("rst_an",   {29'h0, an},   32'h6);
    chk("rst_seg",  {25'h0, seg},  32'h40);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    busy_seen = 1'b0;
    repeat (14) begin
      @(negedge clk_in);
      busy_seen |= busy;
    end
    chk("idle_busy_never", {31'h0, busy_seen}, 32'h0);

    // 0 -> 255: busy for exactly 9 cycles
    drive(8'd255, 12'h255);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk_in);
      chk($sformatf("busy_255_c%0d", i),
          {31'h0, busy}, {31'h0, (i <= 9)});
    end
    repeat (4) @(negedge clk_in);

    // table of conversions
    for (int i = 0; i < 9; i++) begin
      drive(tab[i].v, tab[i].b);
      repeat (14) @(negedge clk_in);
    end

    // change during conversion is deferred
    drive(8'd37, 12'h037);
    k = cyc;
    repeat (3) @(negedge clk_in);
    value = 8'd99;
    sb.push_back('{12'h099, k + 21});
    repeat (26) @(negedge clk_in);

    // steady 128: explicit scan sequence
    drive(8'd128, 12'h128);
    repeat (14) @(negedge clk_in);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_in);
      if (cyc % 12 == 11) break;
    end
    for (int i = 0; i < 13; i++) begin
      @(negedge clk_in);
      chk($sformatf("scan_an_%0d", i), {29'h0, an},
          {29'h0, an_exp[(i % 12) / 4]});
      chk($sformatf("scan_seg_%0d", i), {25'h0, seg},
          {25'h0, sg_exp[(i % 12) / 4]});
    end

    // reset mid-SHIFT with value 200
    @(negedge clk_in);
    value = 8'd200;
    repeat (4) @(negedge clk_in);
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk_in);
    chk("mid_rst_bcd",  {20'h0, bcd},  32'h000);
    chk("mid_rst_an",   {29'h0, an},   32'h6);
    chk("mid_rst_seg",  {25'h0, seg},  32'h40);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk_in);
    rst_n = 1'b1;
    sb.push_back('{12'h200, 11});
    repeat (25) @(negedge clk_in);

    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
